// File: rtl/pll_seq_pkg.sv
// Shared types and 50 MHz defaults for the pixel-clock PLL reset sequencer.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        RESET_PLL,
        WAIT_LOCK,
        STABILIZE,
        RUN,
        FAULT
    } pll_state_t;

    localparam int DEF_RST_PULSE_CYCLES    = 10;
    localparam int DEF_LOCK_TIMEOUT_CYCLES = 50000;
    localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
    localparam int DEF_MAX_RETRIES         = 3;
    localparam int DEF_CNT_W               = 16;
    localparam int DEF_RETRY_W             = 2;

    // Bits needed to hold values 0..max_val.
    function automatic int width_for(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer with asynchronous active-high reset.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_reset_sequencer.sv
// Brings the pixel PLL up through reset/lock/qualification with bounded retries,
// holding sys_rst until lock has been stable for the qualification window.
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RST_PULSE_CYCLES    = DEF_RST_PULSE_CYCLES,
    parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
    parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
    parameter int MAX_RETRIES         = DEF_MAX_RETRIES,
    parameter int CNT_W               = DEF_CNT_W,
    parameter int RETRY_W             = DEF_RETRY_W
) (
    input  logic               refclk,
    input  logic               rst,
    input  logic               pll_locked,
    output logic               pll_rst,
    output logic               sys_rst,
    output logic               ready,
    output logic               fault,
    output logic [RETRY_W-1:0] retry_count,
    output logic               lock_lost
);

    localparam int MAX_A   = (RST_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES) ? RST_PULSE_CYCLES
                                                                        : LOCK_TIMEOUT_CYCLES;
    localparam int MAX_CYC = (MAX_A > LOCK_STABLE_CYCLES) ? MAX_A : LOCK_STABLE_CYCLES;

    if (CNT_W < width_for(MAX_CYC)) begin : g_cnt_w_chk
        $error("CNT_W too narrow for the largest cycle parameter");
    end
    if (RETRY_W < width_for(MAX_RETRIES)) begin : g_retry_w_chk
        $error("RETRY_W too narrow for MAX_RETRIES");
    end
    if (RST_PULSE_CYCLES < 1 || LOCK_TIMEOUT_CYCLES < 1 || LOCK_STABLE_CYCLES < 1) begin : g_cyc_chk
        $error("cycle parameters must be at least 1");
    end

    localparam logic [CNT_W-1:0]   RST_LAST  = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TO_LAST   = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]   STB_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);

    pll_state_t         state, nxt;
    logic [CNT_W-1:0]   cnt;
    logic [RETRY_W-1:0] retry_nxt;
    logic               lock_s;

    sync_2ff #(.WIDTH(1)) u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .d   (pll_locked),
        .q   (lock_s)
    );

    // Lock wins over a coincident timeout, so it is tested first in WAIT_LOCK.
    always_comb begin
        nxt       = state;
        retry_nxt = retry_count;
        case (state)
            RESET_PLL: if (cnt == RST_LAST) nxt = WAIT_LOCK;
            WAIT_LOCK: begin
                if (lock_s) begin
                    nxt = STABILIZE;
                end else if (cnt == TO_LAST) begin
                    if (retry_count == RETRY_MAX) begin
                        nxt = FAULT;
                    end else begin
                        nxt       = RESET_PLL;
                        retry_nxt = retry_count + 1'b1;
                    end
                end
            end
            STABILIZE: begin
                if (!lock_s)              nxt = WAIT_LOCK;
                else if (cnt == STB_LAST) nxt = RUN;
            end
            RUN: begin
                if (!lock_s) begin
                    nxt       = RESET_PLL;
                    retry_nxt = '0;
                end
            end
            FAULT:   nxt = FAULT;
            default: nxt = RESET_PLL;
        endcase
    end

    // Outputs decode the next state so they change on the same edge as the state.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state       <= RESET_PLL;
            cnt         <= '0;
            retry_count <= '0;
            pll_rst     <= 1'b1;
            sys_rst     <= 1'b1;
            ready       <= 1'b0;
            fault       <= 1'b0;
            lock_lost   <= 1'b0;
        end else begin
            state       <= nxt;
            cnt         <= (nxt != state) ? '0 : cnt + 1'b1;
            retry_count <= retry_nxt;
            pll_rst     <= (nxt == RESET_PLL) || (nxt == FAULT);
            sys_rst     <= (nxt != RUN);
            ready       <= (nxt == RUN);
            fault       <= (nxt == FAULT);
            lock_lost   <= (state == RUN) && (nxt == RESET_PLL);
        end
    end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench: expected output snapshots are queued per edge as stimulus is planned.
module tb_pll_reset_sequencer;

    localparam int RSTP = 4, TO = 20, STB = 8, MAXR = 2, CW = 16, RW = 2;

    logic          refclk = 1'b0;
    logic          rst = 1'b1;
    logic          pll_locked = 1'b0;
    logic          pll_rst, sys_rst, ready, fault, lock_lost;
    logic [RW-1:0] retry_count;

    int cyc = 0;
    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        int         cyc;
        string      tag;
        logic [6:0] v;
    } sb_t;
    sb_t sb[$];

    pll_reset_sequencer #(
        .RST_PULSE_CYCLES    (RSTP),
        .LOCK_TIMEOUT_CYCLES (TO),
        .LOCK_STABLE_CYCLES  (STB),
        .MAX_RETRIES         (MAXR),
        .CNT_W               (CW),
        .RETRY_W             (RW)
    ) dut (
        .refclk      (refclk),
        .rst         (rst),
        .pll_locked  (pll_locked),
        .pll_rst     (pll_rst),
        .sys_rst     (sys_rst),
        .ready       (ready),
        .fault       (fault),
        .retry_count (retry_count),
        .lock_lost   (lock_lost)
    );

    always #5 refclk = ~refclk;
    always @(posedge refclk) cyc <= cyc + 1;

    function automatic logic [6:0] st(bit pr, bit sr, bit rd, bit ft, bit ll, int rc);
        return {pr, sr, rd, ft, ll, 2'(rc)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic expect_at(input int c, input string tag, input logic [6:0] v);
        sb_t e;
        e.cyc = c;
        e.tag = tag;
        e.v   = v;
        sb.push_back(e);
    endtask

    // Snapshot is {pll_rst, sys_rst, ready, fault, lock_lost, retry_count}.
    always @(negedge refclk) begin
        sb_t e;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            if (e.cyc < cyc) chk({e.tag, "_late"}, cyc, e.cyc);
            else chk(e.tag, {25'd0, pll_rst, sys_rst, ready, fault, lock_lost, retry_count}, {25'd0, e.v});
        end
    end

    task automatic wait_to(input int c);
        while (cyc < c) begin
            @(posedge refclk);
            #2;
        end
    endtask

    // Returns the edge index after which rst was released.
    task automatic do_reset(output int b);
        @(posedge refclk);
        #3;
        rst = 1'b1;
        pll_locked = 1'b0;
        #1;
        chk("rst_outs", {25'd0, pll_rst, sys_rst, ready, fault, lock_lost, retry_count}, {25'd0, st(1, 1, 0, 0, 0, 0)});
        chk("rst_cnt", 32'(dut.cnt), 0);
        wait_to(cyc + 2);
        rst = 1'b0;
        b = cyc;
    endtask

    initial begin
        int b;

        // 1: normal bring-up
        do_reset(b);
        expect_at(b + 3,  "s1_pulse",    st(1, 1, 0, 0, 0, 0));
        expect_at(b + 4,  "s1_waitlock", st(0, 1, 0, 0, 0, 0));
        expect_at(b + 19, "s1_prerun",   st(0, 1, 0, 0, 0, 0));
        expect_at(b + 20, "s1_run",      st(0, 0, 1, 0, 0, 0));
        expect_at(b + 25, "s1_hold",     st(0, 0, 1, 0, 0, 0));
        wait_to(b + 9);
        pll_locked = 1'b1;
        wait_to(b + 26);

        // 2: two-cycle lock glitch inside STABILIZE
        do_reset(b);
        expect_at(b + 19, "s2_back",    st(0, 1, 0, 0, 0, 0));
        expect_at(b + 20, "s2_noready", st(0, 1, 0, 0, 0, 0));
        expect_at(b + 28, "s2_prerun",  st(0, 1, 0, 0, 0, 0));
        expect_at(b + 29, "s2_run",     st(0, 0, 1, 0, 0, 0));
        wait_to(b + 9);
        pll_locked = 1'b1;
        wait_to(b + 16);
        pll_locked = 1'b0;
        wait_to(b + 18);
        pll_locked = 1'b1;
        wait_to(b + 30);

        // 3: no lock at all -> retries then sticky fault
        do_reset(b);
        expect_at(b + 23,  "s3_to1_pre",  st(0, 1, 0, 0, 0, 0));
        expect_at(b + 24,  "s3_retry1",   st(1, 1, 0, 0, 0, 1));
        expect_at(b + 27,  "s3_pulse2",   st(1, 1, 0, 0, 0, 1));
        expect_at(b + 28,  "s3_wait2",    st(0, 1, 0, 0, 0, 1));
        expect_at(b + 48,  "s3_retry2",   st(1, 1, 0, 0, 0, 2));
        expect_at(b + 52,  "s3_wait3",    st(0, 1, 0, 0, 0, 2));
        expect_at(b + 71,  "s3_prefault", st(0, 1, 0, 0, 0, 2));
        expect_at(b + 72,  "s3_fault",    st(1, 1, 0, 1, 0, 2));
        expect_at(b + 100, "s3_sticky",   st(1, 1, 0, 1, 0, 2));
        wait_to(b + 75);
        pll_locked = 1'b1;
        wait_to(b + 101);

        // 4: lock loss while running, then relock
        do_reset(b);
        expect_at(b + 20, "s4_run",      st(0, 0, 1, 0, 0, 0));
        expect_at(b + 31, "s4_stillrun", st(0, 0, 1, 0, 0, 0));
        expect_at(b + 32, "s4_lost",     st(1, 1, 0, 0, 1, 0));
        expect_at(b + 33, "s4_lostend",  st(1, 1, 0, 0, 0, 0));
        expect_at(b + 36, "s4_wait",     st(0, 1, 0, 0, 0, 0));
        expect_at(b + 44, "s4_prerun",   st(0, 1, 0, 0, 0, 0));
        expect_at(b + 45, "s4_rerun",    st(0, 0, 1, 0, 0, 0));
        wait_to(b + 9);
        pll_locked = 1'b1;
        wait_to(b + 29);
        pll_locked = 1'b0;
        wait_to(b + 33);
        pll_locked = 1'b1;
        wait_to(b + 46);

        // 5: async reset between edges while in STABILIZE
        do_reset(b);
        expect_at(b + 15, "s5_stab", st(0, 1, 0, 0, 0, 0));
        wait_to(b + 9);
        pll_locked = 1'b1;
        wait_to(b + 15);
        #4;
        rst = 1'b1;
        #1;
        chk("s5_async_outs", {25'd0, pll_rst, sys_rst, ready, fault, lock_lost, retry_count}, {25'd0, st(1, 1, 0, 0, 0, 0)});
        chk("s5_async_cnt", 32'(dut.cnt), 0);
        chk("s5_async_sync", 32'(dut.lock_s), 0);

        // 6: lock_s arrives on the timeout edge
        do_reset(b);
        expect_at(b + 23, "s6_pre",     st(0, 1, 0, 0, 0, 0));
        expect_at(b + 24, "s6_nostep",  st(0, 1, 0, 0, 0, 0));
        expect_at(b + 31, "s6_prerun",  st(0, 1, 0, 0, 0, 0));
        expect_at(b + 32, "s6_run",     st(0, 0, 1, 0, 0, 0));
        wait_to(b + 21);
        pll_locked = 1'b1;
        wait_to(b + 33);

        for (int i = 0; i < 100 && sb.size() > 0; i++) @(posedge refclk);
        chk("sb_drain", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
